// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite register bank: response codes and FSM states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,  // never generated by this slave
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    WR_COLLECT,
    WR_COMMIT,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_t;

  // Register index width; a single-register bank still needs one index bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// Byte address -> register index and AXI response for the register window.
// Latency: combinational.
// Backpressure: none (pure decode).
// Ports: addr_i byte address; index_o register index (0 unless OKAY); resp_o OKAY/SLVERR/DECERR.
module axi4_lite_addr_decode
  import axi4_lite_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    NUM_REGISTERS = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS  = 32'h8000_0000,
  localparam int                   IDX_W         = idx_width(NUM_REGISTERS)
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [IDX_W-1:0]      index_o,
  output resp_t                 resp_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(NUM_REGISTERS * BYTES);

  logic [ADDR_WIDTH-1:0] offset;

  always_comb begin
    offset  = addr_i - BASE_ADDRESS;
    index_o = '0;
    // Below-base addresses wrap to a huge offset, but test explicitly for clarity.
    if (addr_i < BASE_ADDRESS || offset >= SPAN) begin
      resp_o = DECERR;
    end else if (offset[LSB-1:0] != '0) begin
      resp_o = SLVERR;
    end else begin
      resp_o  = OKAY;
      index_o = IDX_W'(offset >> LSB);
    end
  end

endmodule

// File: rtl/axi4_lite_regbank.sv
// AXI4-Lite slave register bank with WSTRB masking and per-register read-only mask.
// Latency: write update/wr_pulse/BVALID one edge after the last AW/W handshake; RVALID on the AR handshake edge.
// Backpressure: BVALID/RVALID and their payloads hold until BREADY/RREADY; new AW/W/AR are refused meanwhile.
// Ports: clk, reset (async, active-high); AW/W/B and AR/R channels; reg_out flattened registers;
//        wr_pulse one-cycle per-register update strobe.
module axi4_lite_regbank
  import axi4_lite_pkg::*;
#(
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       ADDR_WIDTH    = 32,
  parameter int                       NUM_REGISTERS = 8,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDRESS  = 32'h8000_0000,
  parameter logic [NUM_REGISTERS-1:0] RO_MASK       = '0,
  localparam int                      STRB_W        = DATA_WIDTH / 8,
  localparam int                      IDX_W         = idx_width(NUM_REGISTERS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ADDR_WIDTH-1:0]           AWADDR,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [DATA_WIDTH-1:0]           WDATA,
  input  logic [STRB_W-1:0]               WSTRB,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [ADDR_WIDTH-1:0]           ARADDR,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  output logic [DATA_WIDTH-1:0]           RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RVALID,
  input  logic                            RREADY,
  output logic [NUM_REGISTERS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGISTERS-1:0]        wr_pulse
);

  // Write path state
  wr_state_t                 wr_state_q;
  logic                      aw_held_q, w_held_q;
  logic                      aw_held_d, w_held_d;
  logic [ADDR_WIDTH-1:0]     awaddr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [STRB_W-1:0]         wstrb_q;
  logic                      awready_q, wready_q, bvalid_q;
  resp_t                     bresp_q;
  logic [NUM_REGISTERS-1:0]  wr_pulse_q;
  logic [DATA_WIDTH-1:0]     regs_q [NUM_REGISTERS];

  // Read path state
  rd_state_t                 rd_state_q;
  logic                      arready_q, rvalid_q;
  resp_t                     rresp_q;
  logic [DATA_WIDTH-1:0]     rdata_q;

  logic [IDX_W-1:0]          wr_idx, rd_idx;
  resp_t                     wr_resp, rd_resp;

  // Write decode works on the held address, read decode on the live ARADDR.
  axi4_lite_addr_decode #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_REGISTERS(NUM_REGISTERS), .BASE_ADDRESS(BASE_ADDRESS)
  ) u_aw_dec (
    .addr_i(awaddr_q), .index_o(wr_idx), .resp_o(wr_resp)
  );

  axi4_lite_addr_decode #(
    .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_REGISTERS(NUM_REGISTERS), .BASE_ADDRESS(BASE_ADDRESS)
  ) u_ar_dec (
    .addr_i(ARADDR), .index_o(rd_idx), .resp_o(rd_resp)
  );

  assign aw_held_d = aw_held_q | (AWVALID & awready_q);
  assign w_held_d  = w_held_q  | (WVALID  & wready_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state_q <= WR_COLLECT;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGISTERS; i++) regs_q[i] <= '0;
    end else begin
      wr_pulse_q <= '0;
      case (wr_state_q)
        WR_COLLECT: begin
          if (AWVALID && awready_q) awaddr_q <= AWADDR;
          if (WVALID && wready_q) begin
            wdata_q <= WDATA;
            wstrb_q <= WSTRB;
          end
          aw_held_q <= aw_held_d;
          w_held_q  <= w_held_d;
          if (aw_held_d && w_held_d) begin
            wr_state_q <= WR_COMMIT;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
          end else begin
            // Also raises both READYs on the first edge out of reset.
            awready_q <= !aw_held_d;
            wready_q  <= !w_held_d;
          end
        end
        WR_COMMIT: begin
          bvalid_q   <= 1'b1;
          wr_state_q <= WR_RESP;
          if (wr_resp != OKAY) begin
            bresp_q <= wr_resp;
          end else if (RO_MASK[wr_idx]) begin
            bresp_q <= SLVERR;
          end else begin
            bresp_q <= OKAY;
            // An all-zero strobe is a legal no-op: OKAY without update or pulse.
            if (|wstrb_q) begin
              for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_q[b]) regs_q[wr_idx][8*b +: 8] <= wdata_q[8*b +: 8];
              end
              wr_pulse_q[wr_idx] <= 1'b1;
            end
          end
        end
        WR_RESP: begin
          if (BREADY) begin
            bvalid_q   <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_state_q <= WR_COLLECT;
          end
        end
        default: wr_state_q <= WR_COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= OKAY;
      rdata_q    <= '0;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          arready_q <= 1'b1;
          if (ARVALID && arready_q) begin
            // Samples the array before any same-edge write commit lands.
            rd_state_q <= RD_RESP;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            rresp_q    <= rd_resp;
            rdata_q    <= (rd_resp == OKAY) ? regs_q[rd_idx] : '0;
          end
        end
        RD_RESP: begin
          if (RREADY) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= RD_IDLE;
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  assign AWREADY  = awready_q;
  assign WREADY   = wready_q;
  assign BVALID   = bvalid_q;
  assign BRESP    = bresp_q;
  assign ARREADY  = arready_q;
  assign RVALID   = rvalid_q;
  assign RRESP    = rresp_q;
  assign RDATA    = rdata_q;
  assign wr_pulse = wr_pulse_q;

  for (genvar i = 0; i < NUM_REGISTERS; i++) begin : g_flat
    assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

endmodule

// File: tb/tb_axi4_lite_regbank.sv
module tb_axi4_lite_regbank;

  localparam logic [7:0]  RO_MASK_TB = 8'h80;
  localparam logic [31:0] BASE       = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]   WSTRB;
  logic         AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic         ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]   BRESP, RRESP;
  logic [255:0] reg_out;
  logic [7:0]   wr_pulse;

  int checks = 0;
  int failures = 0;
  logic [31:0] model [8];

  always #5 clk = ~clk;

  axi4_lite_regbank #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGISTERS(8),
    .BASE_ADDRESS(32'h8000_0000), .RO_MASK(8'h80)
  ) dut (
    .clk(clk), .reset(reset),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_out(reg_out), .wr_pulse(wr_pulse)
  );

  // ---------------- reference model ----------------
  function automatic logic [1:0] exp_decode(input logic [31:0] a);
    if (a < BASE || a >= BASE + 32'd32) return 2'b11;
    if (a % 4 != 0) return 2'b10;
    return 2'b00;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] s, output logic [1:0] resp,
                                      output logic [7:0] pulse);
    int i;
    resp  = exp_decode(a);
    pulse = 8'h00;
    if (resp == 2'b00) begin
      i = int'((a - BASE) / 4);
      if (RO_MASK_TB[i]) resp = 2'b10;
      else if (s != 4'h0) begin
        for (int b = 0; b < 4; b++) if (s[b]) model[i][8*b +: 8] = d[8*b +: 8];
        pulse = 8'(1 << i);
      end
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (exp_decode(a) != 2'b00) return 32'h0;
    return model[(a - BASE) / 4];
  endfunction

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[i*32 +: 32] = model[i];
    return f;
  endfunction

  // ---------------- bus drivers (observe only, no checking) ----------------
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, output logic [1:0] resp,
                           output logic [7:0] pulse, output bit on_time);
    int t;
    bit aw_done, w_done, aw_hs, w_hs, early, bv, late;
    t = 0; aw_done = 0; w_done = 0;
    while (!(aw_done && w_done) && t < 40) begin
      if (!aw_done && t >= aw_dly) begin AWVALID = 1; AWADDR = addr; end
      if (!w_done && t >= w_dly) begin WVALID = 1; WDATA = data; WSTRB = strb; end
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      @(posedge clk); #1;
      if (aw_hs) begin aw_done = 1; AWVALID = 0; end
      if (w_hs)  begin w_done = 1;  WVALID = 0; end
      t++;
    end
    AWVALID = 0; WVALID = 0;
    early = BVALID || (wr_pulse != 8'h00);
    @(posedge clk); #1;
    bv = BVALID; resp = BRESP; pulse = wr_pulse;
    BREADY = 1;
    @(posedge clk); #1;
    BREADY = 0;
    late = BVALID || (wr_pulse != 8'h00);
    on_time = aw_done && w_done && !early && bv && !late;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output bit ok);
    int t;
    bit done, hs;
    ARVALID = 1; ARADDR = addr; t = 0; done = 0;
    while (!done && t < 40) begin
      hs = ARREADY;
      @(posedge clk); #1;
      if (hs) begin done = 1; ARVALID = 0; end
      t++;
    end
    ARVALID = 0; t = 0;
    while (!RVALID && t < 10) begin @(posedge clk); #1; t++; end
    ok = done && RVALID; data = RDATA; resp = RRESP;
    RREADY = 1;
    @(posedge clk); #1;
    RREADY = 0;
    ok = ok && !RVALID;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA, wr_pulse, reg_out} !== '0) begin
      failures++; $display("FAIL reset_outputs: some output nonzero during reset (reg_out=%h)", reg_out);
    end
    reset = 0;
    #1;
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
      failures++; $display("FAIL ready_before_edge: got %b want 000", {AWREADY, WREADY, ARREADY});
    end
    @(posedge clk); #1;
    checks++;
    if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      failures++; $display("FAIL ready_after_reset: got %b want 111", {AWREADY, WREADY, ARREADY});
    end
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
  endtask

  task automatic test_same_cycle();
    logic [1:0] r, er; logic [7:0] p, ep; logic [31:0] d; bit ok;
    model_write(32'h8000_0004, 32'hDEAD_BEEF, 4'hF, er, ep);
    axi_write(32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, r, p, ok);
    checks++; if (!ok) begin failures++; $display("FAIL same_cycle_timing: BVALID/pulse not exactly one edge after handshake"); end
    checks++; if (r !== 2'b00 || r !== er) begin failures++; $display("FAIL same_cycle_bresp: got %b want 00", r); end
    checks++; if (p !== 8'h02 || p !== ep) begin failures++; $display("FAIL same_cycle_pulse: got %h want 02", p); end
    axi_read(32'h8000_0004, d, r, ok);
    checks++; if (!ok || d !== 32'hDEAD_BEEF || r !== 2'b00) begin
      failures++; $display("FAIL same_cycle_read: got %h/%b ok=%0d want deadbeef/00", d, r, ok); end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] r, er; logic [7:0] p, ep; bit ok;
    model_write(32'h8000_0008, 32'hFFFF_FFFF, 4'hF, er, ep);
    axi_write(32'h8000_0008, 32'hFFFF_FFFF, 4'hF, 0, 0, r, p, ok);
    model_write(32'h8000_0008, 32'h1122_3344, 4'b0101, er, ep);
    axi_write(32'h8000_0008, 32'h1122_3344, 4'b0101, 3, 0, r, p, ok);
    checks++; if (!ok || r !== 2'b00 || p !== 8'h04) begin
      failures++; $display("FAIL w_first: resp=%b pulse=%h ok=%0d want 00/04/1", r, p, ok); end
    checks++; if (reg_out[95:64] !== 32'hFF22_FF44) begin
      failures++; $display("FAIL w_first_strobe: reg2=%h want ff22ff44", reg_out[95:64]); end
    // AW leads W by two cycles
    model_write(32'h8000_000C, 32'hCAFE_0001, 4'b1010, er, ep);
    axi_write(32'h8000_000C, 32'hCAFE_0001, 4'b1010, 0, 2, r, p, ok);
    checks++; if (!ok || r !== er || p !== ep || reg_out !== model_flat()) begin
      failures++; $display("FAIL aw_first: resp=%b pulse=%h reg3=%h want %b/%h/%h", r, p, reg_out[127:96], er, ep, model[3]); end
  endtask

  task automatic test_errors();
    logic [1:0] r, er; logic [7:0] p, ep; logic [31:0] d; bit ok;
    model_write(32'h8000_0020, 32'h5555_5555, 4'hF, er, ep);
    axi_write(32'h8000_0020, 32'h5555_5555, 4'hF, 0, 0, r, p, ok);
    checks++; if (!ok || r !== 2'b11 || p !== 8'h00) begin
      failures++; $display("FAIL decerr_write: resp=%b pulse=%h want 11/00", r, p); end
    axi_read(32'h8000_0002, d, r, ok);
    checks++; if (!ok || r !== 2'b10 || d !== 32'h0) begin
      failures++; $display("FAIL slverr_read: resp=%b data=%h want 10/0", r, d); end
    axi_write(32'h7FFF_FFFC, 32'h1, 4'hF, 0, 0, r, p, ok);
    checks++; if (r !== 2'b11 || p !== 8'h00) begin
      failures++; $display("FAIL below_base: resp=%b pulse=%h want 11/00", r, p); end
    axi_write(32'h8000_0005, 32'h1, 4'hF, 0, 0, r, p, ok);
    checks++; if (r !== 2'b10 || p !== 8'h00) begin
      failures++; $display("FAIL misaligned_write: resp=%b pulse=%h want 10/00", r, p); end
    axi_write(32'h8000_0000, 32'hFFFF_FFFF, 4'h0, 0, 0, r, p, ok);
    checks++; if (r !== 2'b00 || p !== 8'h00 || reg_out !== model_flat()) begin
      failures++; $display("FAIL zero_strobe: resp=%b pulse=%h reg0=%h want 00/00/%h", r, p, reg_out[31:0], model[0]); end
  endtask

  task automatic test_read_only();
    logic [1:0] r; logic [7:0] p; logic [31:0] d; bit ok;
    axi_write(32'h8000_001C, 32'h1234_5678, 4'hF, 0, 0, r, p, ok);
    checks++; if (!ok || r !== 2'b10 || p !== 8'h00 || reg_out[255:224] !== 32'h0) begin
      failures++; $display("FAIL ro_write: resp=%b pulse=%h reg7=%h want 10/00/0", r, p, reg_out[255:224]); end
    axi_read(32'h8000_001C, d, r, ok);
    checks++; if (!ok || r !== 2'b00 || d !== 32'h0) begin
      failures++; $display("FAIL ro_read: resp=%b data=%h want 00/0", r, d); end
  endtask

  task automatic test_backpressure();
    logic [1:0] r0, er; logic [7:0] ep; logic [31:0] d0; bit stable; int t;
    AWVALID = 1; AWADDR = 32'h8000_000C; WVALID = 1; WDATA = 32'hA5A5_0F0F; WSTRB = 4'hF;
    checks++; if ({AWREADY, WREADY} !== 2'b11) begin
      failures++; $display("FAIL bp_idle_ready: got %b want 11", {AWREADY, WREADY}); end
    @(posedge clk); #1;
    AWVALID = 0; WVALID = 0;
    model_write(32'h8000_000C, 32'hA5A5_0F0F, 4'hF, er, ep);
    @(posedge clk); #1;
    r0 = BRESP;
    // second write offered while the first response is stalled
    AWVALID = 1; AWADDR = 32'h8000_0010; WVALID = 1; WDATA = 32'h0BAD_F00D; WSTRB = 4'hF;
    stable = BVALID && (r0 == 2'b00);
    for (int i = 0; i < 5; i++) begin
      if (!BVALID || BRESP !== r0 || AWREADY || WREADY || wr_pulse[4]) stable = 0;
      @(posedge clk); #1;
    end
    checks++; if (!stable) begin
      failures++; $display("FAIL b_backpressure: B not held or AW/W accepted (BVALID=%b BRESP=%b)", BVALID, BRESP); end
    BREADY = 1;
    @(posedge clk); #1;
    BREADY = 0;
    checks++; if (BVALID !== 1'b0 || {AWREADY, WREADY} !== 2'b11) begin
      failures++; $display("FAIL b_release: BVALID=%b ready=%b want 0/11", BVALID, {AWREADY, WREADY}); end
    @(posedge clk); #1;
    AWVALID = 0; WVALID = 0;
    model_write(32'h8000_0010, 32'h0BAD_F00D, 4'hF, er, ep);
    @(posedge clk); #1;
    checks++; if (BVALID !== 1'b1 || wr_pulse !== ep || reg_out !== model_flat()) begin
      failures++; $display("FAIL stalled_aw_commit: BVALID=%b pulse=%h want 1/%h", BVALID, wr_pulse, ep); end
    BREADY = 1; @(posedge clk); #1; BREADY = 0;

    ARVALID = 1; ARADDR = 32'h8000_000C;
    @(posedge clk); #1;
    ARVALID = 0; t = 0;
    while (!RVALID && t < 10) begin @(posedge clk); #1; t++; end
    d0 = RDATA; r0 = RRESP; stable = RVALID;
    for (int i = 0; i < 5; i++) begin
      if (!RVALID || RDATA !== d0 || RRESP !== r0 || ARREADY) stable = 0;
      @(posedge clk); #1;
    end
    checks++; if (!stable || d0 !== 32'hA5A5_0F0F || r0 !== 2'b00) begin
      failures++; $display("FAIL r_backpressure: data=%h resp=%b stable=%0d want a5a50f0f/00/1", d0, r0, stable); end
    RREADY = 1; @(posedge clk); #1; RREADY = 0;
    checks++; if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
      failures++; $display("FAIL r_release: RVALID=%b ARREADY=%b want 0/1", RVALID, ARREADY); end
  endtask

  task automatic test_concurrent();
    logic [31:0] old, d; logic [1:0] er, r; logic [7:0] ep; bit ok; int t;
    old = model[5];
    AWVALID = 1; AWADDR = 32'h8000_0014; WVALID = 1; WDATA = 32'h7777_1234; WSTRB = 4'hF;
    @(posedge clk); #1;
    AWVALID = 0; WVALID = 0;
    // AR handshake lands on the same edge as the write commit
    ARVALID = 1; ARADDR = 32'h8000_0014;
    @(posedge clk); #1;
    ARVALID = 0; t = 0;
    while (!RVALID && t < 10) begin @(posedge clk); #1; t++; end
    checks++; if (!RVALID || RDATA !== old) begin
      failures++; $display("FAIL read_during_commit: data=%h want old %h", RDATA, old); end
    checks++; if (BVALID !== 1'b1) begin
      failures++; $display("FAIL concurrent_bvalid: got %b want 1", BVALID); end
    BREADY = 1; RREADY = 1;
    @(posedge clk); #1;
    BREADY = 0; RREADY = 0;
    model_write(32'h8000_0014, 32'h7777_1234, 4'hF, er, ep);
    axi_read(32'h8000_0014, d, r, ok);
    checks++; if (!ok || d !== model[5] || r !== 2'b00) begin
      failures++; $display("FAIL read_after_commit: data=%h want %h", d, model[5]); end
  endtask

  task automatic test_random();
    logic [31:0] a, dat, d, ed; logic [3:0] s; logic [1:0] r, er; logic [7:0] p, ep; bit ok; int sel, k;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8) a = BASE + 32'(4 * sel);
      else if (sel == 8) a = BASE + 32'($urandom_range(0, 31));
      else begin
        k = $urandom_range(0, 3);
        case (k)
          0: a = 32'h8000_0020;
          1: a = 32'h8000_0040 + 32'($urandom_range(0, 15));
          2: a = 32'h7FFF_FFFC;
          default: a = 32'h0000_0010;
        endcase
      end
      if ($urandom_range(0, 1) == 0) begin
        dat = $urandom; s = 4'($urandom_range(0, 15));
        model_write(a, dat, s, er, ep);
        axi_write(a, dat, s, $urandom_range(0, 3), $urandom_range(0, 3), r, p, ok);
        checks++; if (!ok || r !== er || p !== ep || reg_out !== model_flat()) begin
          failures++; $display("FAIL rand_write[%0d]: addr=%h resp=%b pulse=%h ok=%0d want %b/%h", n, a, r, p, ok, er, ep); end
      end else begin
        er = exp_decode(a); ed = model_read(a);
        axi_read(a, d, r, ok);
        checks++; if (!ok || r !== er || d !== ed) begin
          failures++; $display("FAIL rand_read[%0d]: addr=%h data=%h resp=%b want %h/%b", n, a, d, r, ed, er); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; bit ok, quiet; int t;
    AWVALID = 1; AWADDR = 32'h8000_0018; WVALID = 1; WDATA = 32'h6666_6666; WSTRB = 4'hF;
    @(posedge clk); #1;
    AWVALID = 0; WVALID = 0;
    @(posedge clk); #1;
    ARVALID = 1; ARADDR = 32'h8000_0008;
    @(posedge clk); #1;
    ARVALID = 0; t = 0;
    while (!RVALID && t < 10) begin @(posedge clk); #1; t++; end
    checks++; if ({BVALID, RVALID} !== 2'b11) begin
      failures++; $display("FAIL pre_reset_valids: got %b want 11", {BVALID, RVALID}); end
    #1 reset = 1;
    #1;
    checks++; if ({BVALID, RVALID, AWREADY, WREADY, ARREADY} !== 5'b0 || reg_out !== '0 || RDATA !== '0 || wr_pulse !== '0) begin
      failures++; $display("FAIL reset_mid: valids=%b readies=%b reg_out=%h want all 0", {BVALID, RVALID}, {AWREADY, WREADY, ARREADY}, reg_out); end
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    #1;
    checks++; if ({AWREADY, WREADY, ARREADY} !== 3'b000) begin
      failures++; $display("FAIL ready_early_after_reset: got %b want 000", {AWREADY, WREADY, ARREADY}); end
    @(posedge clk); #1;
    checks++; if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
      failures++; $display("FAIL ready_return: got %b want 111", {AWREADY, WREADY, ARREADY}); end
    quiet = 1;
    for (int i = 0; i < 4; i++) begin
      if (BVALID || RVALID || wr_pulse != 8'h00) quiet = 0;
      @(posedge clk); #1;
    end
    checks++; if (!quiet) begin
      failures++; $display("FAIL abandoned_response: response or pulse seen after reset"); end
    axi_read(32'h8000_0018, d, r, ok);
    checks++; if (!ok || d !== 32'h0 || r !== 2'b00) begin
      failures++; $display("FAIL post_reset_read: data=%h resp=%b want 0/00", d, r); end
  endtask

  initial begin
    reset = 1;
    AWADDR = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0; BREADY = 0;
    ARADDR = '0; ARVALID = 0; RREADY = 0;
    test_reset();
    test_same_cycle();
    test_w_before_aw();
    test_errors();
    test_read_only();
    test_backpressure();
    test_concurrent();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
